// File: rtl/rv32i_types.sv
// Shared core types. Holds the branch-predictor counter encoding and the
// saturating-counter step used when training the pattern history table.
package rv32i_types;

    // 2-bit direction counter; bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;

    // One saturating step toward the resolved direction.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
        bp_ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_BITS two-bit saturating counters.
// Ports:
//   clk, rst        clock, synchronous active-low reset (entries -> WNT)
//   rd_idx/rd_ctr   combinational read port
//   wr_en/wr_idx/wr_taken  saturating train port, applied on the rising edge
module bp_pht
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output bp_ctr_t             rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    bp_ctr_t pht_q [ENTRIES];

    // Read sees pre-edge contents; a same-cycle write is not bypassed.
    assign rd_ctr = pht_q[rd_idx];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        always_ff @(posedge clk) begin
            if (!rst) begin
                pht_q[i] <= BP_CTR_RESET;
            end else if (wr_en && (wr_idx == IDX_BITS'(i))) begin
                pht_q[i] <= bp_ctr_next(pht_q[i], wr_taken);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare branch predictor. Fetch PC bits [IDX_BITS+1:2] XOR the global
// history select a 2-bit counter whose MSB is the guess. Execute returns the
// resolved outcome with the index used, which trains the counter, shifts the
// (non-speculative) history and updates hit/miss statistics.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   pred_valid, pred_pc       fetch query
//   pred_taken, pred_idx      combinational prediction and index used
//   upd_valid, upd_idx,
//   upd_taken, upd_pred       resolved branch from execute
//   mispredict                combinational, same cycle as upd_valid
//   br_count, miss_count      saturating registered statistics
module branch_predictor
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_pred,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         miss_count
);

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         br_cnt_q, br_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;
    logic [GHR_BITS:0]   ghr_shift;
    bp_ctr_t             rd_ctr;

    // The prediction is produced whether or not fetch is querying; the
    // upper PC bits and byte offset never take part in the hash.
    logic unused_bits;
    assign unused_bits = ^{pred_valid, pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

    assign pred_idx   = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign pred_taken = rd_ctr[1];
    assign mispredict = upd_valid & (upd_taken != upd_pred);

    bp_pht #(.IDX_BITS(IDX_BITS)) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (upd_valid),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken)
    );

    // Shift through a one-bit-wider vector so GHR_BITS=1 needs no special case.
    assign ghr_shift = {ghr_q, upd_taken};

    always_comb begin
        ghr_d      = ghr_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd_valid) begin
            ghr_d = ghr_shift[GHR_BITS-1:0];
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
            if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_q      <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_count   = br_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .mispredict (mispredict),
        .br_count   (br_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic upd(input logic [5:0] idx, input logic tk, input logic pr);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = tk;
        upd_pred  = pr;
    endtask

    // Expected counter values for four not-taken then one taken update at idx 5.
    logic [1:0] sat_exp [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    initial begin
        rst = 1'b0; pred_valid = 1'b1; pred_pc = 32'h0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        pred_pc = 32'h104; #1;
        chk("rst_idx",   32'(pred_idx), 32'd1);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_br",    br_count, 32'd0);
        chk("rst_miss",  miss_count, 32'd0);
        upd_taken = 1'b1; upd_pred = 1'b0; #1;
        chk("misp_noval", 32'(mispredict), 32'd0);

        // Two taken updates at idx 1, predicted not-taken
        upd(6'd1, 1'b1, 1'b0); #1;
        chk("misp_a", 32'(mispredict), 32'd1);
        step();
        chk("pht1_a", 32'(dut.u_pht.pht_q[1]), 32'd2);
        chk("misp_b", 32'(mispredict), 32'd1);
        step();
        upd_valid = 1'b0;
        chk("pht1_b", 32'(dut.u_pht.pht_q[1]), 32'd3);
        chk("ghr_b",  32'(dut.ghr_q), 32'h03);
        chk("br_b",   br_count, 32'd2);
        chk("miss_b", miss_count, 32'd2);
        pred_pc = 32'h104; #1;
        chk("q104_idx", 32'(pred_idx), 32'd2);
        chk("q104_tk",  32'(pred_taken), 32'd0);
        pred_pc = 32'h108; #1;
        chk("q108_idx", 32'(pred_idx), 32'd1);
        chk("q108_tk",  32'(pred_taken), 32'd1);

        // Counter saturation at idx 5 (GHR stays 0 until the final taken update)
        do_reset();
        pred_pc = 32'h14;
        for (int k = 0; k < 5; k++) begin
            upd(6'd5, (k == 4), 1'b0); #1;
            chk($sformatf("sat_ctr%0d", k), 32'(dut.u_pht.pht_q[5]), 32'(sat_exp[k]));
            chk($sformatf("sat_tk%0d", k), 32'(pred_taken), 32'd0);
            step();
        end
        upd_valid = 1'b0;
        chk("sat_end", 32'(dut.u_pht.pht_q[5]), 32'(sat_exp[5]));
        chk("sat_ghr", 32'(dut.ghr_q), 32'h01);
        chk("sat_br",  br_count, 32'd5);
        chk("sat_miss", miss_count, 32'd1);

        // Same-cycle query and update: no bypass
        do_reset();
        pred_pc = 32'h104;
        upd(6'd1, 1'b1, 1'b0); #1;
        chk("haz_tk", 32'(pred_taken), 32'd0);
        step();
        upd_valid = 1'b0;
        pred_pc = 32'h10C; #1;
        chk("haz_idx",  32'(pred_idx), 32'd2);
        chk("haz_tk2",  32'(pred_taken), 32'd0);
        chk("haz_pht1", 32'(dut.u_pht.pht_q[1]), 32'd2);

        // Reset on the same edge as an update discards it
        rst = 1'b0;
        upd(6'd1, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        upd_valid = 1'b0; #1;
        chk("mr_pht1", 32'(dut.u_pht.pht_q[1]), 32'd1);
        chk("mr_ghr",  32'(dut.ghr_q), 32'd0);
        chk("mr_br",   br_count, 32'd0);
        chk("mr_miss", miss_count, 32'd0);

        // Statistics saturation
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt_q;
        #1;
        chk("ss_pre", miss_count, 32'hFFFF_FFFF);
        upd(6'd7, 1'b1, 1'b0);
        step();
        upd_valid = 1'b0; #1;
        chk("ss_miss", miss_count, 32'hFFFF_FFFF);
        chk("ss_br",   br_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Gshare dynamic branch predictor for the pipelined RV32I core. Fetch queries it with the fetch PC and gets a taken/not-taken guess in the same cycle. Execute later returns the resolved outcome (the comparator's `br_en`) together with the table index the prediction used. The block trains a pattern history table (PHT) of 2-bit saturating counters, shifts a global history register (GHR), flags mispredictions and keeps hit/miss statistics.

## Interface
Parameters:
- `IDX_BITS`, 6, PHT index width; table holds 2^IDX_BITS counters.
- `GHR_BITS`, 6, global history length; legal range 1..IDX_BITS.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-low (asserted when 0).
- `pred_valid`  in  1  fetch is issuing a query this cycle.
- `pred_pc`  in  32  fetch PC.
- `pred_taken`  out  1  predicted direction, combinational from the current state.
- `pred_idx`  out  IDX_BITS  index used for this prediction; carried down the pipeline.
- `upd_valid`  in  1  execute is resolving a conditional branch this cycle.
- `upd_idx`  in  IDX_BITS  `pred_idx` that travelled with the branch.
- `upd_taken`  in  1  resolved outcome (`br_en`).
- `upd_pred`  in  1  prediction that travelled with the branch.
- `mispredict`  out  1  combinational: `upd_valid & (upd_taken != upd_pred)`.
- `br_count`  out  32  number of resolved branches, registered.
- `miss_count`  out  32  number of mispredicted branches, registered.

## Operation
- Index: `pred_idx = pred_pc[IDX_BITS+1:2] ^ {zero-extend GHR to IDX_BITS}`. The PC bits [1:0] are ignored.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- `pred_taken` is bit 1 of the addressed counter. When `pred_valid`=0 the outputs still reflect `pred_pc`; the value is a don't-care for the consumer.
- On an edge with `upd_valid`=1:
  - If taken, `PHT[upd_idx]` increments and saturates at 11.
  - If not taken, it decrements and saturates at 00.
  - `GHR <= {GHR[GHR_BITS-2:0], upd_taken}`.
  - `br_count` increments.
  - If `mispredict`=1, `miss_count` also increments.
  - Both statistics counters saturate at 0xFFFFFFFF; they do not wrap.
- The GHR holds only resolved outcomes, so it is non-speculative and needs no recovery on flush.
- Same-cycle query and update, either on the same index or with a GHR shift: the query sees pre-edge state. There is no bypass.
- `upd_valid`=0: all state holds.
- Reset (`rst`=0 at an edge):
  - Every PHT entry goes to 01.
  - GHR goes to 0.
  - `br_count` and `miss_count` go to 0.
  - Any coincident update is discarded.
  - This applies at any point, including mid-training.

## Timing
- Prediction latency: 0 cycles (combinational path from `pred_pc` to `pred_taken` and `pred_idx`).
- Update latency: new counter, GHR and statistics values are visible in the cycle after the update edge.
- `mispredict` is valid in the same cycle as `upd_valid`, so the pipeline can issue its flush that cycle.
- Reset outputs: `pred_taken`=0 for every PC, `pred_idx`=`pred_pc[IDX_BITS+1:2]`, `mispredict`=0 if `upd_valid`=0, `br_count`=0, `miss_count`=0.
- No handshake or backpressure. Exactly one update per cycle at most; the pipeline guarantees this.

## Structure
- Shared `rv32i_types` package gains:
  - `bp_ctr_t`: 2-bit enum with values `SNT`, `WNT`, `WT`, `ST`.
  - `BP_CTR_RESET = WNT`.
- Sub-module `bp_pht`:
  - Holds the 2^IDX_BITS counter array with synchronous active-low reset.
  - One combinational read port and one saturating-update write port.
- Top level holds the index hash, the GHR, mispredict detection and the statistics counters.

## Test plan
- Reset, then query `pred_pc`=0x00000104 -> `pred_idx`=1, `pred_taken`=0; `br_count`=`miss_count`=0.
- Two updates at idx 1, taken, `upd_pred`=0:
  - `mispredict`=1 both cycles; counter goes 01→10→11; GHR=0x03; `br_count`=2, `miss_count`=2.
  - Query 0x104 -> `pred_idx`=2, `pred_taken`=0.
  - Query 0x108 -> `pred_idx`=1, `pred_taken`=1.
- Saturation: from reset, four not-taken updates at idx 5 followed by one taken update.
  - Counter goes 01→00→00→00→00→01; each update sees `pred_taken`=0 at that index.
  - GHR=0x01 after the sequence.
- Same-cycle hazard: after reset, query 0x104 while updating idx 1 taken.
  - `pred_taken`=0 that cycle.
  - Next cycle, query 0x10C (idx 3^1=2) -> 0, and `PHT[1]`=10.
- Mid-operation reset: `rst`=0 on the same edge as a taken update at idx 1.
  - Next cycle: `PHT[1]`=01, GHR=0, both statistics counters 0.
- Statistics saturation: preload `miss_count`=0xFFFFFFFF through a force, then apply a mispredicted update -> `miss_count` stays 0xFFFFFFFF and `br_count` increments.
